// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver, oversampled by clken, with ready/framing/overrun status
// Optional 2-of-3 majority bit sampling is enabled by defining UART_RX_MAJORITY_EN.
module uart_receiver #(
   parameter int OSR_LOG2 = 4
) (
   input  logic       clk_50m,
   input  logic       rst_n,
   input  logic       rx,
   input  logic       clken,
   input  logic       rdy_clr,
   output logic [7:0] dout,
   output logic       rdy,
   output logic       frame_err,
   output logic       overrun
);

   localparam logic [OSR_LOG2-1:0] SC_LAST = '1;
   localparam logic [OSR_LOG2-1:0] SC_MID  = SC_LAST >> 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t              state_q, state_d;
   logic                sync1_q, sync2_q, rx_s, bit_s;
   logic [OSR_LOG2-1:0] sc_q, sc_d;
   logic [2:0]          bi_q, bi_d;
   logic [7:0]          shreg_q, shreg_d, dout_q, dout_d;
   logic                rdy_q, rdy_d, ferr_q, ferr_d, ovr_q, ovr_d;
   logic                mid_hit, end_hit;

   assign rx_s    = sync2_q;
   assign mid_hit = (sc_q == SC_MID);
   assign end_hit = (sc_q == SC_LAST);

`ifdef UART_RX_MAJORITY_EN
   // hist_q holds rx_s from the two previous ticks, so the vote covers the last three ticks.
   logic [1:0] hist_q;

   always_ff @(posedge clk_50m) begin
      if (!rst_n) begin
         hist_q <= 2'b11;
      end else if (clken) begin
         hist_q <= {hist_q[0], rx_s};
      end
   end

   assign bit_s = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
   assign bit_s = rx_s;
`endif

   always_ff @(posedge clk_50m) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (clken) begin
         case (state_q)
            S_IDLE:  if (!rx_s) state_d = S_START;
            S_START: if (mid_hit) state_d = bit_s ? S_IDLE : S_DATA;
            S_DATA:  if (end_hit && bi_q == 3'd7) state_d = S_STOP;
            S_STOP:  if (end_hit) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      sc_d    = sc_q;
      bi_d    = bi_q;
      shreg_d = shreg_q;
      dout_d  = dout_q;
      rdy_d   = rdy_q;
      ferr_d  = ferr_q;
      ovr_d   = ovr_q;
      if (rdy_clr) begin
         rdy_d = 1'b0;
         ovr_d = 1'b0;
      end
      if (clken) begin
         case (state_q)
            S_IDLE: sc_d = '0;
            S_START: begin
               sc_d = sc_q + 1'b1;
               if (mid_hit) begin
                  sc_d = '0;
                  bi_d = '0;
               end
            end
            S_DATA: begin
               // sc wraps to 0 at the sample point, which also seeds the stop bit count.
               sc_d = sc_q + 1'b1;
               if (end_hit) begin
                  shreg_d[bi_q] = bit_s;
                  bi_d          = bi_q + 1'b1;
               end
            end
            S_STOP: begin
               sc_d = sc_q + 1'b1;
               if (end_hit) begin
                  if (bit_s) begin
                     dout_d = shreg_q;
                     rdy_d  = 1'b1;
                     ferr_d = 1'b0;
                     ovr_d  = ovr_d | (rdy_q & ~rdy_clr);
                  end else begin
                     ferr_d = 1'b1;
                  end
               end
            end
            default: sc_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk_50m) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         sc_q    <= '0;
         bi_q    <= '0;
         shreg_q <= '0;
         dout_q  <= '0;
         rdy_q   <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         sync1_q <= rx;
         sync2_q <= sync1_q;
         sc_q    <= sc_d;
         bi_q    <= bi_d;
         shreg_q <= shreg_d;
         dout_q  <= dout_d;
         rdy_q   <= rdy_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      dout      = dout_q;
      rdy       = rdy_q;
      frame_err = ferr_q;
      overrun   = ovr_q;
   end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage. It is the consumer of the transmitter's `tx` line on the far end of the link (or in loopback).
- Frame format: 8N1.
  - One start bit (0).
  - 8 data bits, LSB first.
  - One stop bit (1).
  - Line idles high.
- Bit timing comes from an oversampling enable pulse supplied by the shared baud generator. The block runs entirely in the `clk_50m` domain.
- It presents each received byte with a ready flag, plus framing and overrun status, to the host logic.

Parameters:
- `OSR_LOG2`, default 4: log2 of the oversampling ratio. Default gives 16 `clken` ticks per bit. Legal range is 3..5.

Ports:
- `clk_50m`  input  1  system clock, all logic on the rising edge
- `rst_n`  input  1  synchronous active-low reset, sampled on the rising edge of `clk_50m`
- `rx`  input  1  asynchronous serial input, idle high
- `clken`  input  1  oversample tick, one `clk_50m` cycle wide, (2^`OSR_LOG2`) ticks per bit period
- `rdy_clr`  input  1  host acknowledge; clears `rdy` and `overrun`
- `dout`  output  8  last good received byte
- `rdy`  output  1  high when `dout` holds an unacknowledged byte
- `frame_err`  output  1  high when the most recent frame had a stop bit sampled as 0
- `overrun`  output  1  sticky; a good byte completed while `rdy` was already high

Behaviour:
- Reset (`rst_n`=0 at a clock edge):
  - `dout`=8'h00, `rdy`=0, `frame_err`=0, `overrun`=0.
  - State goes to IDLE; sample counter, bit index and shift register are cleared.
  - Synchronizer flops are set to 1.
  - Reset mid-frame abandons the frame with no output update.
- `rx` input path:
  - Passes through a 2-flop synchronizer; `rx_s` is the second flop.
  - All decisions use `rx_s`, which adds 2 cycles of latency.
- Counters:
  - `N` = 2^`OSR_LOG2`.
  - The sample counter `sc` is `OSR_LOG2` bits wide and wraps naturally.
  - It advances only on cycles where `clken` is high.
  - All state transitions below occur only on `clken` cycles. Non-`clken` cycles hold state.
- IDLE:
  - On `clken` with `rx_s`=0: go to START, `sc`=0.
- START:
  - On each `clken`, `sc`++.
  - When `sc`=N/2-1 (mid start bit), sample:
    - `rx_s`=0: go to DATA with `sc`=0 and bit index `bi`=0.
    - `rx_s`=1: glitch; return to IDLE. No flag changes.
- DATA:
  - On each `clken`, `sc`++.
  - When `sc`=N-1 (one bit period after the previous sample point):
    - Sampled bit goes into `shreg[bi]`.
    - If `bi`=7, go to STOP with `sc`=0; otherwise `bi`++.
- STOP:
  - On each `clken`, `sc`++.
  - When `sc`=N-1, sample and then go to IDLE:
    - Sample = 1:
      - `dout` <= `shreg`, `rdy` <= 1, `frame_err` <= 0.
      - `overrun` <= 1 if `rdy` was already 1 and `rdy_clr` is not asserted this cycle.
    - Sample = 0:
      - `frame_err` <= 1.
      - `dout`, `rdy` and `overrun` are unchanged.
- Returning to IDLE at mid-stop-bit allows back-to-back frames with no gap.
- `rdy_clr` handling:
  - `rdy_clr`=1 clears `rdy` and `overrun` on the next edge.
  - If `rdy_clr` coincides with a good stop sample, the set wins: `rdy`=1 and `overrun`=0.
  - `rdy_clr` has no effect on `frame_err`.
- Latency: `rdy` rises on the edge at the middle of the stop bit, plus 2 cycles of synchronizer delay after the line event.
- `clken` never asserted: the block holds its state indefinitely.

Optional Feature:
- Macro: `UART_RX_MAJORITY_EN`.
- Defined:
  - Each sampled bit (start, data, stop) is the 2-of-3 majority of `rx_s` captured at the three `clken` ticks ending at the sample point.
    - Start bit: `sc`=N/2-3..N/2-1.
    - Data/stop bits: `sc`=N-3..N-1.
  - The decision is made on the same tick as in the single-sample mode, so timing is unchanged.
  - A single-tick glitch within the window is rejected.
- Undefined: single sample of `rx_s` at the sample point; no extra flops.

Test Plan:
- Reset/idle:
  - Stimulus: `rst_n`=0 for 4 cycles, `rx`=1, `clken` every 27 cycles (115200 baud, 16x).
  - Required response: `dout`=00, `rdy`=0, `frame_err`=0, `overrun`=0; stays IDLE for 1000 cycles.
- Single byte:
  - Stimulus: drive frame 0x A5 (line bits 0,1,0,1,0,0,1,0,1,1).
  - Required response: `rdy` rises once mid-stop, `dout`=8'hA5, `frame_err`=0. `rdy_clr` pulse then gives `rdy`=0.
- Back-to-back with overrun:
  - Stimulus: frames 0x3C then 0xC3 with no idle gap and no `rdy_clr`.
  - Required response: `dout`=C3, `rdy`=1, `overrun`=1. One `rdy_clr` clears both.
- Framing error:
  - Stimulus: frame 0x55 with the stop bit forced to 0.
  - Required response: `frame_err`=1, `rdy` unchanged, `dout` unchanged. The next good frame 0x12 gives `frame_err`=0 and `dout`=12.
- False start:
  - Stimulus: `rx` low for 4 ticks only.
  - Required response: return to IDLE, no flags set. A following frame 0x81 is received correctly.
- Loopback and reset mid-frame:
  - Stimulus: connect to the transmitter (`tx`→`rx`) with a shared `clk_50m`, transmitter `clken` = every 16th receiver tick; send 0x00, 0xFF, 0x5A.
  - Required response: all three are received in order with `frame_err`=0.
  - Then assert `rst_n` during data bit 3: no `rdy` and `dout`=00. The next frame is received correctly.
  - With `UART_RX_MAJORITY_EN`: a 1-tick high glitch mid-bit during frame 0x00 still yields `dout`=00.
